voq_rr_scheduler: RTL and testbench
===================================

# voq_rr_scheduler

Per-output read scheduler for the shared-buffer switch. It drives the `rd_en`/`rd_sel` inputs of `switch_moudle`, one engine per egress port. For each port it picks a non-empty source sub-queue in round-robin order and drains it for a bounded burst. It stalls on downstream backpressure and moves the round-robin pointer when the burst ends or the queue empties.

## Interface
Parameters:
- `PORT_NUB_TOTAL`, default `` `PORT_NUB_TOTAL `` (4): number of ports N.
- `BURST_MAX`, default 4: maximum words read from one source queue per grant; legal range 1..16.
- `WIDTH_SEL`, derived, $clog2(PORT_NUB_TOTAL): source index width W.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sched_en` in 1: global enable; gates new grants only.
- `empty` in N*N: bit o*N+s is high when the VOQ of output o, source s, is empty. It is registered in the VOQ and updates on the same edge as the read.
- `out_ready` in N: egress o can accept a word this cycle.
- `rd_en` out N: read strobe per output VOQ; connects to `switch_moudle.rd_en`.
- `rd_sel` out N*W: source index per output, bits [(o+1)*W-1 : o*W]; connects to `switch_moudle.rd_sel`.
- `busy` out N: engine o is in SERVE.

## Operation
- N independent engines. Each engine has state {IDLE, SERVE}, a pointer `ptr` (W bits), a current source `cur` (W bits) and a burst count `bcnt` (0..BURST_MAX-1).
- IDLE:
  - If `sched_en`=1 and any `empty[o*N+s]`=0, set `cur` to the first non-empty s scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Clear `bcnt` and go to SERVE. No read is issued in this cycle.
  - Otherwise stay in IDLE.
- SERVE:
  - `rd_en[o]` = `out_ready[o]` & ~`empty[o*N+cur]`. This is combinational from registered state and inputs.
  - `rd_sel[o]` = `cur` at all times, including in IDLE, where it holds the last value.
- A read completes in a cycle where `rd_en[o]`=1. On that edge:
  - If `bcnt`=BURST_MAX-1, the burst ends.
  - Otherwise `bcnt` increments.
- If `empty[o*N+cur]`=1 in SERVE, the burst ends without a read, regardless of `out_ready`.
- `out_ready[o]`=0 with a non-empty queue holds SERVE: `bcnt` frozen, no timeout.
- Burst end: `ptr` ← `cur`+1, wrapping N-1→0; this must also hold for non-power-of-2 N. State → IDLE.
- `sched_en` dropping during SERVE does not abort the burst; only new grants are blocked.
- Engines never interact. Simultaneous grants on all outputs are legal because each VOQ is per output.

## Timing
- Reset values: state IDLE, `ptr`=0, `cur`=0, `bcnt`=0. Outputs after reset: `rd_en`=0, `rd_sel`=0, `busy`=0.
- Grant latency: first `rd_en` one cycle after IDLE sees a non-empty queue, assuming `out_ready`=1.
- Throughput: BURST_MAX reads in consecutive cycles, then one IDLE bubble cycle per grant. Peak rate is BURST_MAX/(BURST_MAX+1) words per cycle per port.
- A queue holding exactly k < BURST_MAX words:
  - k reads issue back to back.
  - The cycle after the k-th read sees `empty`=1, which ends the burst.
  - `rd_en` is never asserted on an empty queue.
- Reset asserted mid-burst returns the engine to reset values immediately and asynchronously. `rd_en` falls without waiting for a clock.

## Structure
- `PORT_NUB_TOTAL` and `DATA_WIDTH` come from the shared `generate_parameter.vh`. The state encodings (IDLE=0, SERVE=1) are defined there as well.
- The first-set-from-pointer search is a function in the include file, so the switch and scheduler share it.
- One sub-module, `rr_port_sched`, implements a single engine. The top generates N instances and slices `empty`, `rd_sel` and `rd_en` per output.

## Test plan
- Reset release with all queues empty: `rd_en`=0, `busy`=0 for 20 cycles; `ptr` stays 0.
- N=4, BURST_MAX=4; output 0, sources 1 and 3 hold 6 words each; `out_ready`=1:
  - Reads from source 1 for 4 cycles, then one bubble cycle, then source 3 for 4 cycles, then source 1 for 2 cycles.
  - `rd_sel` sequence matches exactly.
- Single word queued at output 2, source 0: exactly one `rd_en` pulse. Then `ptr`=1 and the engine returns to IDLE.
- Backpressure: in SERVE, `out_ready[1]`=0 for 5 cycles mid-burst. `rd_en[1]`=0 throughout, `bcnt` is unchanged, and the burst resumes with its remaining count.
- Wrap-around: `ptr`=3 and only source 2 is non-empty. Source 2 is granted, then `ptr`=3. With N=3, a burst on source 2 sets `ptr`=0.
- `sched_en` cleared mid-burst: the current burst completes. No further grants occur while `sched_en`=0; granting resumes one cycle after it is re-enabled.

Source files
------------

// File: rtl/voq_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : voq_rr_scheduler_pkg
// Description : Shared definitions for the VOQ read scheduler: default port
//               count, engine state encoding, burst counter width and the
//               first-set-from-pointer search shared with the switch.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package voq_rr_scheduler_pkg;

  localparam int DEFAULT_PORT_NUB_TOTAL = 4;

  localparam int                 STATE_W  = 1;
  localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;
  localparam logic [STATE_W-1:0] ST_SERVE = 1'b1;

  // BURST_MAX is at most 16, so the count 0..BURST_MAX-1 fits in 4 bits.
  localparam int BCNT_W = 4;

  // Upper bound on the request vector handled by the search function.
  localparam int RR_MAX_N = 64;

  // Returns the index of the first set bit of req[n-1:0] when scanning
  // ptr, ptr+1, ..., n-1, 0, ..., ptr-1. Returns 0 when nothing is set;
  // callers qualify the result with their own any-request term. Scanning
  // from the far end lets the nearest hit overwrite the result last, which
  // keeps the loop free of early exits.
  function automatic int rr_first_set(input logic [RR_MAX_N-1:0] req,
                                      input int                  n,
                                      input int                  ptr);
    logic [RR_MAX_N-1:0] rot;
    int                  idx;
    rr_first_set = 0;
    for (int k = RR_MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        rot = req >> idx;
        if (rot[0]) rr_first_set = idx;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/voq_rr_scheduler_port.sv
`default_nettype none
// ============================================================================
// Module      : rr_port_sched
// Description : One egress read engine. In IDLE it grants the first
//               non-empty source at or after ptr; in SERVE it reads that
//               source for up to BURST_MAX words, stalling on out_ready and
//               ending early when the source runs empty.
// Ports       : clk, rst_n      - clock, async active-low reset
//               sched_en        - allows new grants
//               empty[N-1:0]    - per-source empty flags for this output
//               out_ready       - egress can accept a word
//               rd_en           - read strobe to the VOQ
//               rd_sel[W-1:0]   - source being read (held in IDLE)
//               busy            - engine is in SERVE
// Revision    : 1.0 - initial release
// ============================================================================
module rr_port_sched
  import voq_rr_scheduler_pkg::*;
#(
  parameter int N         = 4,
  parameter int BURST_MAX = 4,
  parameter int W         = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sched_en,
  input  logic [N-1:0] empty,
  input  logic         out_ready,
  output logic         rd_en,
  output logic [W-1:0] rd_sel,
  output logic         busy
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [W-1:0]       ptr;
  logic [W-1:0]       cur;
  logic [W-1:0]       pick;
  logic [BCNT_W-1:0]  bcnt;
  logic               cur_empty;
  logic               any_req;
  logic               grant;
  logic               last;
  logic               burst_end;

  assign any_req   = ~&empty;
  assign cur_empty = empty[cur];
  assign last      = (bcnt == BCNT_W'(BURST_MAX - 1));
  assign pick      = W'(rr_first_set(RR_MAX_N'(~empty), N, int'(ptr)));
  assign grant     = (state == ST_IDLE) && sched_en && any_req;

  // An empty source ends the burst with no read even when out_ready is low;
  // otherwise the last word of the burst ends it only once it is accepted.
  assign burst_end = (state == ST_SERVE) && (cur_empty || (out_ready && last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant)     state_nxt = ST_SERVE;
      ST_SERVE: if (burst_end) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b0;
    if (state == ST_SERVE) begin
      busy  = 1'b1;
      rd_en = out_ready && !cur_empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      cur  <= '0;
      bcnt <= '0;
    end else begin
      if (grant) begin
        cur  <= pick;
        bcnt <= '0;
      end else if (rd_en && !last) begin
        bcnt <= bcnt + 1'b1;
      end
      // Explicit wrap so non-power-of-2 port counts return to source 0.
      if (burst_end) begin
        ptr <= (cur == W'(N - 1)) ? '0 : cur + 1'b1;
      end
    end
  end

  assign rd_sel = cur;

endmodule
`default_nettype wire

// File: rtl/voq_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : voq_rr_scheduler
// Description : Per-output round-robin read scheduler for the shared-buffer
//               switch. One independent rr_port_sched engine per egress port.
// Ports       : clk, rst_n               - clock, async active-low reset
//               sched_en                 - global grant enable
//               empty[N*N-1:0]           - bit o*N+s: VOQ(o,s) empty
//               out_ready[N-1:0]         - egress o can accept a word
//               rd_en[N-1:0]             - read strobe per output
//               rd_sel[N*W-1:0]          - source index per output
//               busy[N-1:0]              - engine o serving a burst
// Revision    : 1.0 - initial release
// ============================================================================
module voq_rr_scheduler
  import voq_rr_scheduler_pkg::*;
#(
  parameter int PORT_NUB_TOTAL = DEFAULT_PORT_NUB_TOTAL,
  parameter int BURST_MAX      = 4,
  parameter int WIDTH_SEL      = (PORT_NUB_TOTAL > 1) ? $clog2(PORT_NUB_TOTAL) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  sched_en,
  input  logic [PORT_NUB_TOTAL*PORT_NUB_TOTAL-1:0] empty,
  input  logic [PORT_NUB_TOTAL-1:0]             out_ready,
  output logic [PORT_NUB_TOTAL-1:0]             rd_en,
  output logic [PORT_NUB_TOTAL*WIDTH_SEL-1:0]   rd_sel,
  output logic [PORT_NUB_TOTAL-1:0]             busy
);

  for (genvar o = 0; o < PORT_NUB_TOTAL; o++) begin : g_port
    rr_port_sched #(
      .N         (PORT_NUB_TOTAL),
      .BURST_MAX (BURST_MAX),
      .W         (WIDTH_SEL)
    ) u_eng (
      .clk       (clk),
      .rst_n     (rst_n),
      .sched_en  (sched_en),
      .empty     (empty[o*PORT_NUB_TOTAL +: PORT_NUB_TOTAL]),
      .out_ready (out_ready[o]),
      .rd_en     (rd_en[o]),
      .rd_sel    (rd_sel[o*WIDTH_SEL +: WIDTH_SEL]),
      .busy      (busy[o])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_voq_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_voq_rr_scheduler
// Description : Self-checking bench for voq_rr_scheduler (N=4 and N=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voq_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int BM = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           sched_en;
  logic [N*N-1:0] empty;
  logic [N-1:0]   out_ready;
  logic [N-1:0]   rd_en;
  logic [N*W-1:0] rd_sel;
  logic [N-1:0]   busy;

  logic [8:0]     empty3;
  logic [2:0]     out_ready3;
  logic [2:0]     rd_en3;
  logic [5:0]     rd_sel3;
  logic [2:0]     busy3;

  int checks = 0;
  int errors = 0;

  // Queue occupancy and scheduler model state (N=4 instance).
  int cnt   [N][N];
  int m_busy[N];
  int m_ptr [N];
  int m_cur [N];
  int m_bcnt[N];

  bit capture;
  int seq0[$];
  int seq2[$];
  int pulses2;

  always #5 clk = ~clk;

  voq_rr_scheduler #(.PORT_NUB_TOTAL(N), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .empty(empty),
    .out_ready(out_ready), .rd_en(rd_en), .rd_sel(rd_sel), .busy(busy)
  );

  voq_rr_scheduler #(.PORT_NUB_TOTAL(3), .BURST_MAX(BM)) dut3 (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .empty(empty3),
    .out_ready(out_ready3), .rd_en(rd_en3), .rd_sel(rd_sel3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      m_busy[o] = 0; m_ptr[o] = 0; m_cur[o] = 0; m_bcnt[o] = 0;
    end
  endtask

  // Reference behaviour of one clock edge for every output.
  task automatic model_edge();
    for (int o = 0; o < N; o++) begin
      if (m_busy[o] == 0) begin
        if (sched_en) begin
          int found;
          found = -1;
          for (int k = 0; k < N; k++) begin
            int s;
            s = (m_ptr[o] + k) % N;
            if (found < 0 && cnt[o][s] > 0) found = s;
          end
          if (found >= 0) begin
            m_cur[o] = found; m_bcnt[o] = 0; m_busy[o] = 1;
          end
        end
      end else if (cnt[o][m_cur[o]] == 0) begin
        m_ptr[o] = (m_cur[o] + 1) % N; m_busy[o] = 0;
      end else if (out_ready[o]) begin
        cnt[o][m_cur[o]]--;
        if (m_bcnt[o] == BM - 1) begin
          m_ptr[o] = (m_cur[o] + 1) % N; m_busy[o] = 0;
        end else begin
          m_bcnt[o]++;
        end
      end
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cycle();
    for (int o = 0; o < N; o++)
      for (int s = 0; s < N; s++)
        empty[o*N+s] = (cnt[o][s] == 0);
    #1;
    for (int o = 0; o < N; o++) begin
      logic exp_en;
      exp_en = (m_busy[o] != 0) && out_ready[o] && (cnt[o][m_cur[o]] > 0);
      check($sformatf("rd_en[%0d]", o),  32'(rd_en[o]), 32'(exp_en));
      check($sformatf("rd_sel[%0d]", o), 32'(rd_sel[o*W +: W]), 32'(m_cur[o]));
      check($sformatf("busy[%0d]", o),   32'(busy[o]), 32'(m_busy[o] != 0));
    end
    if (capture && rd_en[0]) seq0.push_back(int'(rd_sel[1:0]));
    if (capture && rd_en[2]) begin
      seq2.push_back(int'(rd_sel[5:4]));
      pulses2++;
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c3[3];
    int seq3[$];
    int exp0[10];

    rst_n = 1'b0; sched_en = 1'b0; out_ready = '0; empty = '1;
    empty3 = '1; out_ready3 = '1;
    capture = 1'b0; pulses2 = 0;
    for (int o = 0; o < N; o++) for (int s = 0; s < N; s++) cnt[o][s] = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    check("reset rd_en",  32'(rd_en),  32'(0));
    check("reset rd_sel", 32'(rd_sel), 32'(0));
    check("reset busy",   32'(busy),   32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset with every queue empty.
    sched_en = 1'b1; out_ready = '1;
    run(20);

    // Output 0: sources 1 and 3 hold six words each.
    cnt[0][1] = 6; cnt[0][3] = 6;
    capture = 1'b1;
    run(22);
    exp0 = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1};
    check("seq0 length", 32'(seq0.size()), 32'(12));
    for (int i = 0; i < 10; i++)
      if (i < seq0.size()) check($sformatf("seq0[%0d]", i), 32'(seq0[i]), 32'(exp0[i]));

    // Single word on output 2 source 0, then ptr must favour source 1.
    cnt[2][0] = 1;
    run(6);
    check("single pulse count", 32'(pulses2), 32'(1));
    seq2.delete();
    cnt[2][0] = 1; cnt[2][1] = 1;
    run(8);
    check("out2 after single first sel", 32'(seq2.size() > 0 ? seq2[0] : -1), 32'(1));
    capture = 1'b0;

    // Backpressure mid-burst on output 1.
    cnt[1][2] = 8;
    run(3);
    check("bcnt before stall", 32'(dut.g_port[1].u_eng.bcnt), 32'(2));
    out_ready[1] = 1'b0;
    run(5);
    check("bcnt after stall", 32'(dut.g_port[1].u_eng.bcnt), 32'(2));
    out_ready[1] = 1'b1;
    run(14);

    // Wrap-around on output 3: move ptr to 3, then only source 2 pending.
    cnt[3][2] = 1;
    run(5);
    cnt[3][2] = 2;
    run(6);
    cnt[3][3] = 1; cnt[3][2] = 1;
    run(8);

    // Three-port instance: a burst on source 2 must wrap ptr to 0.
    c3 = '{0, 0, 2};
    for (int i = 0; i < 14; i++) begin
      if (i == 7) begin c3[0] = 1; c3[2] = 1; end
      for (int s = 0; s < 3; s++) empty3[s] = (c3[s] == 0);
      #1;
      if (rd_en3[0]) seq3.push_back(int'(rd_sel3[1:0]));
      @(posedge clk);
      if (rd_en3[0] && int'(rd_sel3[1:0]) < 3) c3[rd_sel3[1:0]]--;
      @(negedge clk);
    end
    check("n3 read count", 32'(seq3.size()), 32'(4));
    if (seq3.size() == 4) begin
      check("n3 seq[1]", 32'(seq3[1]), 32'(2));
      check("n3 seq[2] wraps", 32'(seq3[2]), 32'(0));
      check("n3 seq[3]", 32'(seq3[3]), 32'(2));
    end
    empty3 = '1;

    // sched_en dropped mid-burst.
    cnt[0][0] = 8;
    run(3);
    sched_en = 1'b0;
    run(7);
    sched_en = 1'b1;
    run(12);

    // Asynchronous reset mid-burst.
    cnt[0][2] = 5;
    run(3);
    rst_n = 1'b0;
    #1;
    check("async rst rd_en",  32'(rd_en),  32'(0));
    check("async rst busy",   32'(busy),   32'(0));
    check("async rst rd_sel", 32'(rd_sel), 32'(0));
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    run(12);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      for (int o = 0; o < N; o++) begin
        out_ready[o] = ($urandom_range(0, 3) != 0);
        for (int s = 0; s < N; s++)
          if ($urandom_range(0, 15) == 0) cnt[o][s] += $urandom_range(1, 6);
      end
      sched_en = ($urandom_range(0, 9) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
